// File: rtl/systolic_result_drain.sv
// systolic_result_drain: snapshots the N x M result matrix on capture and streams it out one row per beat
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   array_in     N x M 32-bit result matrix from the systolic array
//   capture      single-cycle request to snapshot array_in and start draining
//   out_ready    downstream ready
//   out_valid    row beat valid
//   out_row      current row data (zero when out_valid is low)
//   out_row_idx  index of the current row
//   out_last     high on the beat carrying row N-1
//   busy         high while streaming
//   done         one-cycle pulse after the final row is accepted
//   overrun      one-cycle pulse when capture arrives while streaming
// Optional: define DRAIN_RELU_EN to clamp negative output words to zero (buffer keeps raw values).
module systolic_result_drain #(
  parameter int M = 256,
  parameter int N = 256,
  localparam int RW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N-1:0][M-1:0][31:0]    array_in,
  input  logic                         capture,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [M-1:0][31:0]           out_row,
  output logic [RW-1:0]                out_row_idx,
  output logic                         out_last,
  output logic                         busy,
  output logic                         done,
  output logic                         overrun
);
  typedef enum logic {IDLE, STREAM} state_t;
  state_t state, state_nx;
  logic [RW-1:0] cnt, cnt_nx;
  logic [N-1:0][M-1:0][31:0] snap;
  logic at_last;
  assign at_last = (cnt == RW'(N - 1));
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      done    <= (state == STREAM) && out_ready && at_last;
      overrun <= (state == STREAM) && capture;
    end
  // Snapshot storage is deliberately left unreset; only a capture in IDLE writes it.
  always_ff @(posedge clk)
    if (state == IDLE && capture) snap <= array_in;
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (state == IDLE) begin
      if (capture) begin
        state_nx = STREAM;
        cnt_nx   = '0;
      end
    end else if (out_ready) begin
      state_nx = at_last ? IDLE : STREAM;
      cnt_nx   = at_last ? '0 : cnt + RW'(1);
    end
  end
  // Outputs depend only on registered state, so an asynchronous reset drops them at once.
  always_comb begin
    out_valid   = (state == STREAM);
    busy        = out_valid;
    out_row_idx = cnt;
    out_last    = out_valid && at_last;
    out_row     = '0;
    for (int j = 0; j < M; j++) begin
`ifdef DRAIN_RELU_EN
      out_row[j] = (out_valid && !snap[cnt][j][31]) ? snap[cnt][j] : 32'h0;
`else
      out_row[j] = out_valid ? snap[cnt][j] : 32'h0;
`endif
    end
  end
endmodule

// File: tb/tb_systolic_result_drain.sv
// tb_systolic_result_drain: scoreboard bench for systolic_result_drain with N=4, M=4
module tb_systolic_result_drain;
  localparam int N = 4;
  localparam int M = 4;
  localparam int RW = 2;
  localparam int W = M * 32;

  logic clk = 0;
  logic rst;
  logic [N-1:0][M-1:0][31:0] arr;
  logic capture, out_ready;
  logic out_valid, out_last, busy, done, overrun;
  logic [M-1:0][31:0] out_row;
  logic [RW-1:0] out_row_idx;

  systolic_result_drain #(.M(M), .N(N)) dut (
    .clk(clk), .rst(rst), .array_in(arr), .capture(capture), .out_ready(out_ready),
    .out_valid(out_valid), .out_row(out_row), .out_row_idx(out_row_idx), .out_last(out_last),
    .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    logic last;
    logic [M-1:0][31:0] row;
  } beat_t;

  beat_t q[$];
  int left;
  logic exp_done, exp_ov;
  int errors = 0;
  int checks = 0;
  int beats = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] relu(input logic [31:0] w);
`ifdef DRAIN_RELU_EN
    return $signed(w) < 0 ? 32'h0 : w;
`else
    return w;
`endif
  endfunction

  // Reference model: a capture seen while idle queues all N rows of the matrix as it is at that edge.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      left = 0;
      exp_done = 0;
      exp_ov = 0;
    end else begin
      exp_done = 0;
      exp_ov = 0;
      if (left > 0) begin
        if (capture) exp_ov = 1;
        if (out_ready) begin
          left--;
          if (left == 0) exp_done = 1;
        end
      end else if (capture) begin
        for (int i = 0; i < N; i++) begin
          beat_t b;
          b.idx = i;
          b.last = (i == N - 1);
          for (int j = 0; j < M; j++) b.row[j] = relu(arr[i][j]);
          q.push_back(b);
        end
        left = N;
      end
    end
  end

  // Monitor: compares DUT outputs against the queue head, pops on handshake.
  always @(negedge clk) begin
    chk("valid", W'(out_valid), W'(left > 0));
    chk("busy", W'(busy), W'(left > 0));
    chk("done", W'(done), W'(exp_done));
    chk("overrun", W'(overrun), W'(exp_ov));
    if (out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_beat", W'(out_valid), W'(0));
      end else begin
        chk("row_idx", W'(out_row_idx), W'(q[0].idx));
        chk("last", W'(out_last), W'(q[0].last));
        chk("row", out_row, q[0].row);
        if (out_ready) begin
          void'(q.pop_front());
          beats++;
        end
      end
    end else begin
      chk("idle_row", out_row, '0);
      chk("idle_last", W'(out_last), W'(0));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (left != 0 && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) chk("drain_timeout", W'(left), W'(0));
    step();
  endtask

  task automatic fill_pattern();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < M; j++) arr[i][j] = 32'(16 * i + j);
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < M; j++) arr[i][j] = $urandom;
  endtask

  initial begin
    rst = 0;
    capture = 0;
    out_ready = 0;
    arr = '0;
    repeat (3) step();
    chk("rst_idx", W'(out_row_idx), W'(0));
    chk("rst_row", out_row, '0);
    chk("rst_valid", W'(out_valid), W'(0));
    rst = 1;
    step();
    chk("post_rst_idx", W'(out_row_idx), W'(0));

    fill_pattern();
    beats = 0;
    capture = 1;
    out_ready = 1;
    step();
    capture = 0;
    chk("first_beat_latency", W'(out_valid), W'(1));
    chk("first_beat_idx", W'(out_row_idx), W'(0));
    step();
    step();
    chk("row2_word0", W'(out_row[0]), W'(32'h20));
    chk("row2_word3", W'(out_row[3]), W'(32'h23));
    wait_idle();
    chk("drain_beats", W'(beats), W'(N));

    beats = 0;
    capture = 1;
    step();
    capture = 0;
    step();
    out_ready = 0;
    repeat (3) step();
    chk("stall_idx", W'(out_row_idx), W'(1));
    chk("stall_word1", W'(out_row[1]), W'(32'h11));
    out_ready = 1;
    wait_idle();
    chk("stall_beats", W'(beats), W'(N));

    beats = 0;
    capture = 1;
    step();
    capture = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < M; j++) arr[i][j] = 32'hFFFF;
    step();
    step();
    capture = 1;
    step();
    capture = 0;
    wait_idle();
    chk("overrun_beats", W'(beats), W'(N));

    fill_random();
    beats = 0;
    capture = 1;
    step();
    capture = 0;
    repeat (3) step();
    capture = 1;
    step();
    fill_random();
    step();
    capture = 0;
    wait_idle();
    chk("b2b_beats", W'(beats), W'(2 * N));

    fill_pattern();
    beats = 0;
    capture = 1;
    step();
    capture = 0;
    step();
    rst = 0;
    #1;
    chk("async_valid", W'(out_valid), W'(0));
    chk("async_busy", W'(busy), W'(0));
    chk("async_row", out_row, '0);
    step();
    rst = 1;
    step();
    capture = 1;
    step();
    capture = 0;
    chk("restart_idx", W'(out_row_idx), W'(0));
    wait_idle();
    chk("async_beats", W'(beats), W'(N + 1));

    fill_pattern();
    arr[0][0] = 32'hFFFF_FFFB;
    capture = 1;
    step();
    capture = 0;
`ifdef DRAIN_RELU_EN
    chk("relu_word0", W'(out_row[0]), W'(32'h0));
`else
    chk("relu_word0", W'(out_row[0]), W'(32'hFFFF_FFFB));
`endif
    wait_idle();

    for (int r = 0; r < 60; r++) begin
      fill_random();
      capture = ($urandom_range(3) == 0);
      out_ready = ($urandom_range(3) != 0);
      step();
    end
    capture = 0;
    out_ready = 1;
    wait_idle();
    chk("final_queue", W'(q.size()), W'(0));
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
